// File: rtl/a0_trace_monitor_if.sv
// -----------------------------------------------------------------------------
// a0_trace_monitor_if
//
// Purpose:
//   Valid/ready stream that carries buffered a0 trace samples from the trace
//   monitor to the consumer (testbench, trace logger or display driver).
//
// Signals:
//   out_valid  monitor -> consumer  FIFO head holds a sample
//   out_ready  consumer -> monitor  consumer takes the head this cycle
//   out_data   monitor -> consumer  head sample value (DATA_WIDTH)
//   out_stamp  monitor -> consumer  head sample cycle stamp (CNT_WIDTH)
//
// Modports:
//   master  producer side (the trace monitor)
//   slave   consumer side
// -----------------------------------------------------------------------------
interface a0_trace_monitor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  out_stamp;

    modport master (
        output out_valid,
        output out_data,
        output out_stamp,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_stamp,
        output out_ready
    );
endinterface : a0_trace_monitor_if

// File: rtl/a0_trace_monitor.sv
// -----------------------------------------------------------------------------
// a0_trace_monitor
//
// Purpose:
//   Receive-side observer of the CPU a0 (x10) result bus. Each enabled cycle
//   it samples a0, tags the sample with a free-running cycle stamp and pushes
//   it into a small first-word-fall-through FIFO. The FIFO drains over a
//   valid/ready stream. The block only observes a0; it never drives the core.
//
// Parameters:
//   DATA_WIDTH  width of a0 and out_data
//   CNT_WIDTH   width of the cycle stamp counter and out_stamp
//   FIFO_DEPTH  number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clk       rising-edge clock, shared with the CPU
//   rst       synchronous active-high reset
//   en        sample enable; the stamp counter advances only while high
//   a0        CPU a0 value
//   trace     stream interface (master): out_valid/out_ready/out_data/out_stamp
//   level     current FIFO occupancy, 0..FIFO_DEPTH
//   overflow  sticky flag: a sample was dropped because the FIFO was full
//
// Build option:
//   A0_TRACE_CHANGE_ONLY_EN  when defined, a sample is pushed only for the
//                            first enabled cycle after reset or when a0
//                            differs from the previously enabled sample.
//                            When undefined every enabled cycle is pushed.
// -----------------------------------------------------------------------------
module a0_trace_monitor #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_WIDTH-1:0]         a0,
    a0_trace_monitor_if.master            trace,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CNT_WIDTH-1:0]  stamp;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]  stamp;
    logic [DATA_WIDTH-1:0] prev_a0;
    logic                  seen_first;

    entry_t                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Registered copy of the FIFO head; keeps the last popped entry when the
    // FIFO runs empty so the outputs never show stale memory contents.
    entry_t                head;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic             full;
    logic             empty;
    logic             sample_changed;
    logic             qualifies;
    logic             push_req;
    logic             pop;
    logic             push;
    logic             drop;
    entry_t           new_entry;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] level_next;
    entry_t           head_next;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    assign sample_changed = !seen_first || (a0 != prev_a0);

`ifdef A0_TRACE_CHANGE_ONLY_EN
    assign qualifies = sample_changed;
`else
    assign qualifies = 1'b1;

    // History tracking is kept in both builds so the change-only variant is a
    // pure decode change; this sink only marks the signal as deliberately idle.
    logic unused_change;
    assign unused_change = sample_changed;
`endif

    assign push_req = en && qualifies;

    // A pop needs a valid head; ready on an empty FIFO is ignored.
    assign pop = !empty && trace.out_ready;

    // When full, a push still fits if the head leaves in the same cycle.
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    // The stored stamp is the value before this cycle's increment.
    assign new_entry = '{data: a0, stamp: stamp};

    assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    // Next head: the entry that rd_next will point at. If that slot is the one
    // being written this cycle (FIFO empty after the pop), forward the new
    // sample since memory has not captured it yet. If the FIFO ends up empty,
    // hold the head so the last popped entry stays visible.
    always_comb begin
        head_next = head;
        if (level_next != '0) begin
            if (push && (wr_ptr == rd_next)) begin
                head_next = new_entry;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sample storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; the pointers and level define which
    // slots are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp      <= '0;
            prev_a0    <= '0;
            seen_first <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            overflow   <= 1'b0;
        end else begin
            // Stamp and change history follow en only, independent of
            // whether the sample was stored, dropped or filtered.
            if (en) begin
                stamp      <= stamp + 1'b1;
                prev_a0    <= a0;
                seen_first <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            level <= level_next;
            head  <= head_next;

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stream outputs
    // -------------------------------------------------------------------------
    assign trace.out_valid = !empty;
    assign trace.out_data  = head.data;
    assign trace.out_stamp = head.stamp;

endmodule : a0_trace_monitor

// File: tb/tb_a0_trace_monitor.sv
// -----------------------------------------------------------------------------
// tb_a0_trace_monitor
//
// Drives two monitor instances with identical stimulus: one with a 16-bit
// stamp, one with a 4-bit stamp to exercise wrap-around. A queue-based model
// predicts the stream head, level and overflow after every clock edge.
// -----------------------------------------------------------------------------
module tb_a0_trace_monitor;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int CW_W  = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] a0;
    logic          rdy;

    logic [LW-1:0] level;
    logic [LW-1:0] level_w;
    logic          overflow;
    logic          overflow_w;

    a0_trace_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW))   tif   ();
    a0_trace_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_W)) tif_w ();

    assign tif.out_ready   = rdy;
    assign tif_w.out_ready = rdy;

    a0_trace_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a0       (a0),
        .trace    (tif),
        .level    (level),
        .overflow (overflow)
    );

    a0_trace_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_W), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a0       (a0),
        .trace    (tif_w),
        .level    (level_w),
        .overflow (overflow_w)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: an unbounded-stamp queue of samples
    // -------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   stamp;
    } sample_t;

    sample_t       q[$];
    sample_t       m_last;
    int unsigned   m_stamp;
    logic [DW-1:0] m_prev;
    bit            m_seen;
    bit            m_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input logic [DW-1:0] a, input bit rd);
        bit          pop;
        bit          qual;
        int          sz;
        if (r) begin
            q.delete();
            m_last  = '{data: '0, stamp: 0};
            m_stamp = 0;
            m_prev  = '0;
            m_seen  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            sz  = q.size();
            pop = (sz != 0) && rd;
`ifdef A0_TRACE_CHANGE_ONLY_EN
            qual = !m_seen || (a != m_prev);
`else
            qual = 1'b1;
`endif
            if (pop) m_last = q.pop_front();
            if (e && qual) begin
                if (sz == DEPTH && !pop) m_ovf = 1'b1;
                else                     q.push_back('{data: a, stamp: m_stamp});
            end
            if (e) begin
                m_stamp++;
                m_prev = a;
                m_seen = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] exp_data;
        int unsigned   exp_stamp;
        exp_data  = (q.size() != 0) ? q[0].data  : m_last.data;
        exp_stamp = (q.size() != 0) ? q[0].stamp : m_last.stamp;
        check("valid",      64'(tif.out_valid),   64'(q.size() != 0));
        check("data",       64'(tif.out_data),    64'(exp_data));
        check("stamp",      64'(tif.out_stamp),   64'(exp_stamp % (1 << CW)));
        check("level",      64'(level),           64'(q.size()));
        check("overflow",   64'(overflow),        64'(m_ovf));
        check("valid_w",    64'(tif_w.out_valid), 64'(q.size() != 0));
        check("data_w",     64'(tif_w.out_data),  64'(exp_data));
        check("stamp_w",    64'(tif_w.out_stamp), 64'(exp_stamp % (1 << CW_W)));
        check("level_w",    64'(level_w),         64'(q.size()));
        check("overflow_w", 64'(overflow_w),      64'(m_ovf));
    endtask

    // One clock: apply inputs, let the edge happen, update model, compare.
    task automatic cycle(input bit r, input bit e, input logic [DW-1:0] a, input bit rd);
        rst = r;
        en  = e;
        a0  = a;
        rdy = rd;
        @(posedge clk);
        model_edge(r, e, a, rd);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a0  = '0;
        rdy = 1'b0;

        do_reset(2);

        // Steady/changing a0 with a free-flowing consumer.
        begin
            logic [DW-1:0] seq [6];
            seq = '{32'd5, 32'd5, 32'd5, 32'd7, 32'd7, 32'd9};
            for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, seq[i], 1'b1);
            for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        end

        // Fill past capacity with the consumer stalled.
        do_reset(1);
        for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b1, DW'(i), 1'b0);
        check("fill_level", 64'(level), 64'(q.size()));

        // Full FIFO streaming: push and pop every cycle.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, DW'(100 + i), 1'b1);

        // Backpressure with a valid head, then drain one per cycle.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Mid-stream reset with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(200 + i), 1'b0);
        do_reset(2);
        cycle(1'b0, 1'b1, 32'h55, 1'b0);

        // Stamp wrap on the narrow instance: 18 enabled cycles, then en low.
        do_reset(1);
        for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, DW'(300 + i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, DW'(400 + i), 1'b1);
        cycle(1'b0, 1'b1, 32'h77, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic: small a0 alphabet so repeats are common,
        // two phases with different consumer bias, rare resets.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  DW'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 149) == 0,
                  $urandom_range(0, 2) != 0,
                  DW'($urandom_range(0, 5)),
                  $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_a0_trace_monitor
